// File: rtl/mem_port_sched_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_sched_pkg
// Shared definitions for the memory port scheduler:
//   state_t              - 2-bit FSM state encoding for the port scheduler
//   OP_RD / OP_WR        - op-type codes stored with a captured data request
//   DEFAULT_MEM_LATENCY  - default number of cycles an access holds the port
//   is_data_state()      - true when the port is serving the MAR/MDR path
// ---------------------------------------------------------------------------
package mem_port_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA_RD = 2'd1,
      DATA_WR = 2'd2,
      FETCH   = 2'd3
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam int DEFAULT_MEM_LATENCY = 2;

   function automatic logic is_data_state(input state_t s);
      return (s == DATA_RD) || (s == DATA_WR);
   endfunction

endpackage

// File: rtl/mem_port_sched_req_slot.sv
// ---------------------------------------------------------------------------
// mem_req_slot
// One request slot of the memory port scheduler. Captures a single-cycle
// request pulse together with its address payload, holds it pending until
// the scheduler grants it, and flags a request that arrives while the slot
// is still occupied (pending, or its access is in flight and not on the
// final cycle). A dropped request leaves the stored request untouched.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req        - single-cycle request pulse
//   addr       - payload sampled with req (the data slot carries the op bit
//                in the MSB above the MAR address)
//   grant      - scheduler takes the pending request on this edge
//   active     - this slot's access occupies the port and is not finishing
//   pending    - request waiting for the port
//   addr_q     - captured payload
//   err        - one-cycle pulse after a dropped request
// ---------------------------------------------------------------------------
module mem_req_slot
   import mem_port_sched_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [PAYLOAD_WIDTH-1:0] addr,
   input  logic                     grant,
   input  logic                     active,
   output logic                     pending,
   output logic [PAYLOAD_WIDTH-1:0] addr_q,
   output logic                     err
);

   logic occupied;
   logic accept;

   // The slot frees up on the closing edge of its access (active is already
   // low on the final cycle), so a request on that edge is accepted.
   assign occupied = pending | active;
   assign accept   = req & ~occupied;

   // Grant and accept never coincide: grant needs pending, which blocks accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         addr_q  <= '0;
         err     <= 1'b0;
      end else begin
         err <= req & occupied;
         if (accept) begin
            pending <= 1'b1;
            addr_q  <= addr;
         end else if (grant) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_port_sched.sv
// ---------------------------------------------------------------------------
// mem_port_sched
// Schedules the single shared memory port between the data path (MAR/MDR
// rd/wr micro-ops) and instruction fetch (PC/MBR fetch micro-op). Requests
// are captured into two slots, data wins over fetch, each access holds the
// port for MEM_LATENCY cycles and ends with the MDR/MBR strobe.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   rd_req, wr_req   - data read / write request pulses (MAR address)
//   fetch_req        - instruction fetch request pulse (PC address)
//   mar_addr, pc_addr- addresses sampled with their request pulses
//   mem_addr, mem_en - memory address and access-active flag
//   mem_we           - write enable, final cycle of a write only
//   mdr_mem_read     - MDR latches memory at the end of a read
//   mdr_mem_write    - MDR drives the bus for the whole write
//   mbr_load         - MBR latches memory at the end of a fetch
//   data_stall       - data request pending or in progress
//   fetch_busy       - fetch request pending or in progress
//   err              - one-cycle pulse on an illegal or dropped request
// ---------------------------------------------------------------------------
module mem_port_sched
   import mem_port_sched_pkg::*;
#(
   parameter int WORD_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req,
   input  logic                  wr_req,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] mar_addr,
   input  logic [ADDR_WIDTH-1:0] pc_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic                  mdr_mem_read,
   output logic                  mdr_mem_write,
   output logic                  mbr_load,
   output logic                  data_stall,
   output logic                  fetch_busy,
   output logic                  err
);

   // WORD_WIDTH only documents the MDR width this port is paired with.
   if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || WORD_WIDTH < 1) begin : g_param_check
      $error("mem_port_sched: MEM_LATENCY must be 1..15 and WORD_WIDTH positive");
   end

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic                  conflict_q;

   logic                  data_req, data_pending, data_grant, data_active, data_err;
   logic [ADDR_WIDTH:0]   data_q;
   logic                  fetch_pending, fetch_grant, fetch_active, fetch_err;
   logic [ADDR_WIDTH-1:0] fetch_q;
   logic                  last_cycle;

   // rd and wr together is illegal and neither is captured.
   assign data_req     = rd_req ^ wr_req;
   assign last_cycle   = (cnt_q == 4'd0);
   assign data_active  = is_data_state(state_q) & ~last_cycle;
   assign fetch_active = (state_q == FETCH) & ~last_cycle;

   mem_req_slot #(.PAYLOAD_WIDTH(ADDR_WIDTH + 1)) u_data_slot (
      .clk     (clk),
      .rst     (rst),
      .req     (data_req),
      .addr    ({(wr_req ? OP_WR : OP_RD), mar_addr}),
      .grant   (data_grant),
      .active  (data_active),
      .pending (data_pending),
      .addr_q  (data_q),
      .err     (data_err)
   );

   mem_req_slot #(.PAYLOAD_WIDTH(ADDR_WIDTH)) u_fetch_slot (
      .clk     (clk),
      .rst     (rst),
      .req     (fetch_req),
      .addr    (pc_addr),
      .grant   (fetch_grant),
      .active  (fetch_active),
      .pending (fetch_pending),
      .addr_q  (fetch_q),
      .err     (fetch_err)
   );

   // State, latency counter and the address held for the current access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         cur_addr_q <= '0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_addr_q <= cur_addr_d;
         conflict_q <= rd_req & wr_req;
      end
   end

   // Grant point is IDLE or the final access cycle, so consecutive accesses
   // run back to back. Data always wins; fetch therefore waits behind at most
   // one data access because a data slot cannot refill while in flight.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_addr_d  = cur_addr_q;
      data_grant  = 1'b0;
      fetch_grant = 1'b0;
      if (state_q == IDLE || last_cycle) begin
         if (data_pending) begin
            data_grant = 1'b1;
            state_d    = (data_q[ADDR_WIDTH] == OP_WR) ? DATA_WR : DATA_RD;
            cnt_d      = LAT_M1;
            cur_addr_d = data_q[ADDR_WIDTH-1:0];
         end else if (fetch_pending) begin
            fetch_grant = 1'b1;
            state_d     = FETCH;
            cnt_d       = LAT_M1;
            cur_addr_d  = fetch_q;
         end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Moore output decode from state and the final-cycle flag.
   assign mem_en        = (state_q != IDLE);
   assign mem_addr      = (state_q != IDLE) ? cur_addr_q : '0;
   assign mem_we        = (state_q == DATA_WR) & last_cycle;
   assign mdr_mem_read  = (state_q == DATA_RD) & last_cycle;
   assign mdr_mem_write = (state_q == DATA_WR);
   assign mbr_load      = (state_q == FETCH) & last_cycle;
   assign data_stall    = data_pending | is_data_state(state_q);
   assign fetch_busy    = fetch_pending | (state_q == FETCH);
   assign err           = data_err | fetch_err | conflict_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// ---------------------------------------------------------------------------
// tb_mem_port_sched
// Scoreboard bench for mem_port_sched. The stimulus side steps a
// transaction-level model of the port (pending requests, which access owns
// the port and at which edge it closes) and pushes expected strobes and
// error pulses into queues plus per-cycle expected levels. A separate
// monitor samples the DUT on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_mem_port_sched;

   localparam int LAT  = 2;
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_req = 1'b0, wr_req = 1'b0, fetch_req = 1'b0;
   logic [7:0] mar_addr = 8'h00, pc_addr = 8'h00;
   logic [7:0] mem_addr;
   logic       mem_en, mem_we, mdr_mem_read, mdr_mem_write, mbr_load;
   logic       data_stall, fetch_busy, err;

   mem_port_sched #(.WORD_WIDTH(8), .ADDR_WIDTH(8), .MEM_LATENCY(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .rd_req        (rd_req),
      .wr_req        (wr_req),
      .fetch_req     (fetch_req),
      .mar_addr      (mar_addr),
      .pc_addr       (pc_addr),
      .mem_addr      (mem_addr),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mdr_mem_read  (mdr_mem_read),
      .mdr_mem_write (mdr_mem_write),
      .mbr_load      (mbr_load),
      .data_stall    (data_stall),
      .fetch_busy    (fetch_busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: kind 0 none, 1 read, 2 write, 3 fetch.
   typedef struct {
      int         kind;
      logic [7:0] addr;
      int         cycle;
   } ev_t;

   ev_t        strobe_q[$];
   int         err_q[$];
   int         cyc = 0;
   bit         exp_valid = 1'b0;
   bit         m_dp, m_dwr, m_fp;
   logic [7:0] m_da, m_fa, m_addr;
   int         m_kind, m_end;

   bit         e_en[MAXC], e_ds[MAXC], e_fb[MAXC], e_mw[MAXC];
   logic [7:0] e_addr[MAXC];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic modelReset();
      m_dp = 0; m_dwr = 0; m_fp = 0; m_da = 8'h00; m_fa = 8'h00;
      m_kind = 0; m_addr = 8'h00; m_end = 0;
      strobe_q.delete();
      err_q.delete();
      exp_valid = 1'b0;
   endtask

   // One clock edge of the abstract port: the port frees at the closing edge
   // of an access; a slot is occupied while its request waits or its access
   // has not yet reached that closing edge.
   task automatic modelStep(input bit rd, input bit wr, input bit fe,
                            input logic [7:0] mar, input logic [7:0] pc);
      bit d_occ, f_occ, err_now;
      cyc++;
      d_occ = m_dp || ((m_kind == 1 || m_kind == 2) && m_end > cyc);
      f_occ = m_fp || (m_kind == 3 && m_end > cyc);
      if (m_kind == 0 || m_end == cyc) begin
         if (m_dp) begin
            m_kind = m_dwr ? 2 : 1; m_addr = m_da; m_dp = 0;
         end else if (m_fp) begin
            m_kind = 3; m_addr = m_fa; m_fp = 0;
         end else begin
            m_kind = 0;
         end
         if (m_kind != 0) begin
            m_end = cyc + LAT;
            strobe_q.push_back('{kind: m_kind, addr: m_addr, cycle: cyc + LAT - 1});
         end
      end
      err_now = 0;
      if (rd && wr) err_now = 1;
      else if (rd || wr) begin
         if (d_occ) err_now = 1;
         else begin m_dp = 1; m_dwr = wr; m_da = mar; end
      end
      if (fe) begin
         if (f_occ) err_now = 1;
         else begin m_fp = 1; m_fa = pc; end
      end
      if (err_now) err_q.push_back(cyc);
      e_en[cyc]   = (m_kind != 0);
      e_addr[cyc] = (m_kind != 0) ? m_addr : 8'h00;
      e_ds[cyc]   = m_dp || m_kind == 1 || m_kind == 2;
      e_fb[cyc]   = m_fp || m_kind == 3;
      e_mw[cyc]   = (m_kind == 2);
      exp_valid   = 1'b1;
   endtask

   task automatic applyStimulus(input bit rd, input bit wr, input bit fe,
                                input logic [7:0] mar, input logic [7:0] pc);
      rd_req = rd; wr_req = wr; fetch_req = fe; mar_addr = mar; pc_addr = pc;
      @(posedge clk);
      modelStep(rd, wr, fe, mar, pc);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mem_en"}, 32'(mem_en), 0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 0);
      checkOutput({tag, "_strobes"}, 32'({mem_we, mdr_mem_read, mdr_mem_write, mbr_load}), 0);
      checkOutput({tag, "_flags"}, 32'({data_stall, fetch_busy, err}), 0);
   endtask

   // Asynchronous reset asserted mid-cycle; an aborted access must vanish.
   task automatic pulseReset();
      #1 rst = 1'b1;
      rd_req = 0; wr_req = 0; fetch_req = 0;
      modelReset();
      #1 checkAllZero("async_reset");
      @(posedge clk);
      #1 checkAllZero("reset_hold");
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: level checks every cycle, strobe/err events popped from queues.
   initial begin : monitor
      logic [2:0] sv, want;
      ev_t e;
      forever begin
         @(negedge clk);
         if (!rst && exp_valid && cyc < MAXC) begin
            checkOutput("mem_en", 32'(mem_en), 32'(e_en[cyc]));
            checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
            checkOutput("data_stall", 32'(data_stall), 32'(e_ds[cyc]));
            checkOutput("fetch_busy", 32'(fetch_busy), 32'(e_fb[cyc]));
            checkOutput("mdr_mem_write", 32'(mdr_mem_write), 32'(e_mw[cyc]));
            while (strobe_q.size() > 0 && strobe_q[0].cycle < cyc) begin
               checkOutput("strobe_missed_cycle", 32'(cyc), 32'(strobe_q[0].cycle));
               void'(strobe_q.pop_front());
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
               checkOutput("err_missed_cycle", 32'(cyc), 32'(err_q[0]));
               void'(err_q.pop_front());
            end
            sv = {mbr_load, mem_we, mdr_mem_read};
            if (sv != 3'b000) begin
               if (strobe_q.size() == 0) checkOutput("strobe_unexpected", 32'(sv), 0);
               else begin
                  e = strobe_q.pop_front();
                  want = (e.kind == 1) ? 3'b001 : (e.kind == 2) ? 3'b010 : 3'b100;
                  checkOutput("strobe_kind", 32'(sv), 32'(want));
                  checkOutput("strobe_addr", 32'(mem_addr), 32'(e.addr));
                  checkOutput("strobe_cycle", 32'(cyc), 32'(e.cycle));
               end
            end
            if (err) begin
               if (err_q.size() == 0) checkOutput("err_unexpected", 32'(err), 0);
               else checkOutput("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
         end
      end
   end

   initial begin : stimulus
      modelReset();
      repeat (3) @(posedge clk);
      #1 checkAllZero("reset_state");
      @(negedge clk);
      #1 rst = 1'b0;

      // Single read, then single write.
      applyStimulus(1, 0, 0, 8'h12, 8'h00); idle(5);
      applyStimulus(0, 1, 0, 8'h34, 8'h00); idle(5);
      // Read and fetch on the same edge: back to back, data first.
      applyStimulus(1, 0, 1, 8'h10, 8'h40); idle(6);
      // Second read while the first is in flight is dropped.
      applyStimulus(1, 0, 0, 8'h10, 8'h00);
      applyStimulus(1, 0, 0, 8'h55, 8'h00); idle(5);
      // Read exactly on the closing edge of the previous read is accepted.
      applyStimulus(1, 0, 0, 8'h61, 8'h00); idle(LAT);
      applyStimulus(1, 0, 0, 8'h62, 8'h00); idle(5);
      // Illegal rd+wr.
      applyStimulus(1, 1, 0, 8'h77, 8'h00); idle(4);
      // Back-to-back fetches, second dropped.
      applyStimulus(0, 0, 1, 8'h00, 8'h81);
      applyStimulus(0, 0, 1, 8'h00, 8'h82); idle(5);
      // Reset during access cycle 1 of a write, then a fresh read.
      applyStimulus(0, 1, 0, 8'h3c, 8'h00);
      idle(1);
      pulseReset();
      applyStimulus(1, 0, 0, 8'h21, 8'h00); idle(5);

      // Randomized traffic.
      for (int i = 0; i < 900; i++) begin
         applyStimulus($urandom_range(99) < 18, $urandom_range(99) < 12,
                       $urandom_range(99) < 22, 8'($urandom), 8'($urandom));
      end
      idle(10);

      checkOutput("strobe_queue_drained", 32'(strobe_q.size()), 0);
      checkOutput("err_queue_drained", 32'(err_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Schedules the single shared memory port between the data path (MAR/MDR: rd, wr micro-ops) and the instruction fetch path (PC/MBR: fetch micro-op).
- Captures one-cycle request pulses from the microsequencer and latches the request addresses.
- Arbitrates between data and fetch, holds each access for a fixed memory latency, then drives the MDR mem_read/mem_write and MBR load strobes.
- Provides stall/busy flags so the microsequencer waits instead of consuming stale MDR/MBR contents.

Parameters:
- WORD_WIDTH, 8, data word width; carried for consistency with the MDR, not used internally.
- ADDR_WIDTH, 8, memory address width.
- MEM_LATENCY, 2, cycles each access holds the memory port; legal values are 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  single-cycle pulse: read memory at mar_addr into MDR.
- wr_req  in  1  single-cycle pulse: write MDR contents to memory at mar_addr.
- fetch_req  in  1  single-cycle pulse: fetch byte at pc_addr into MBR.
- mar_addr  in  ADDR_WIDTH  MAR value, sampled on the edge that samples rd_req/wr_req.
- pc_addr  in  ADDR_WIDTH  PC value, sampled on the edge that samples fetch_req.
- mem_addr  out  ADDR_WIDTH  address to memory; held for the whole access.
- mem_en  out  1  memory access active.
- mem_we  out  1  write enable; high on the final cycle of a write access only.
- mdr_mem_read  out  1  to MDR mem_read; high on the final cycle of a read; MDR latches the mem bus at the closing edge.
- mdr_mem_write  out  1  to MDR mem_write; high for all cycles of a write access (MDR drives the bus).
- mbr_load  out  1  high on the final cycle of a fetch; MBR latches at the closing edge.
- data_stall  out  1  data request pending or in progress.
- fetch_busy  out  1  fetch request pending or in progress.
- err  out  1  one-cycle pulse on an illegal or dropped request.

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - State goes to IDLE; pending flags, captured addresses and the counter clear to 0.
  - All outputs go to 0, including mem_addr.
  - An aborted access produces no strobe.
- Request capture:
  - At a posedge with rd_req or wr_req high, set the data pending flag, store the op type and store mar_addr.
  - At a posedge with fetch_req high, set the fetch pending flag and store pc_addr.
  - Capture happens in any state.
- Error cases (each pulses err for the next cycle):
  - rd_req and wr_req high together: both are ignored.
  - A new data request while a data request is pending or in progress: the new one is dropped, the old one is kept.
  - The same rule applies to the fetch slot.
- FSM states: IDLE, DATA_RD, DATA_WR, FETCH.
- Grant (evaluated in IDLE, or in the final access cycle when cnt==0):
  - Priority is data over fetch (wr/rd share one slot).
  - On grant, clear that slot's pending flag, load cnt=MEM_LATENCY-1, move to the access state and drive mem_addr from the slot address.
  - With nothing pending, return to IDLE.
- Back-to-back accesses have no IDLE bubble.
- Starvation: fetch waits at most one data access; a data request cannot be re-raised while one is still in flight.
- Latency, request sampled at edge E:
  - Access occupies cycles E+1 through E+MEM_LATENCY.
  - MDR/MBR latch at edge E+1+MEM_LATENCY.
  - The slot is free to accept a new request at that edge.
- Output decode: all outputs are Moore, decoded from state and cnt==0; mem_en=1 in every access state.
- Stall flags:
  - data_stall = data pending OR state in {DATA_RD, DATA_WR}.
  - fetch_busy = fetch pending OR state==FETCH.
  - Both drop combinationally in the cycle after the latching edge.
- cnt is 4 bits; no wrap is possible within the legal MEM_LATENCY range.

Decomposition:
- Shared header ijvm_mem_defs.vh holds:
  - FSM state encodings (2-bit).
  - the op-type codes OP_RD and OP_WR.
  - the MEM_LATENCY default.
- One sub-module, mem_req_slot, instantiated twice (data and fetch). It contains the pending flag, address register, optional op-type register and overflow-to-err detection. Its inputs are req, addr and grant; its outputs are pending, addr_q and err.

Test Plan (MEM_LATENCY=2):
- rd_req pulse, mar_addr=0x12 at edge 0:
  - mem_en=1 and mem_addr=0x12 during cycles 1-2.
  - mdr_mem_read=1 in cycle 2; data_stall=1 cycles 0-2, 0 in cycle 3.
- wr_req pulse, mar_addr=0x34:
  - mdr_mem_write=1 for both access cycles.
  - mem_we=1 only on the second; mem_addr=0x34 throughout.
- rd_req (0x10) and fetch_req (pc 0x40) on the same edge:
  - Read occupies cycles 1-2; fetch occupies cycles 3-4 with no idle gap.
  - mbr_load=1 in cycle 4.
- Second rd_req (0x55) during an in-flight read of 0x10:
  - err=1 for one cycle; mem_addr never shows 0x55; the original read completes normally.
- rd_req and wr_req high together: err=1, no access (mem_en stays 0), data_stall stays 0.
- rst asserted mid-write (access cycle 1):
  - Outputs go to 0 immediately, with no mem_we pulse.
  - After release, a fresh rd_req completes with standard latency.
